// File: rtl/pll_phase_step_ctrl.sv
// pll_phase_step_ctrl: drives the GTP_PLL_E3 dynamic fine-phase pins.
// It accepts one phase-shift request, issues the step pulses with the
// configured spacing, issues load_phase, then waits for PLL lock and
// reports done or err as single-cycle pulses.
module pll_phase_step_ctrl #(
  parameter int STEP_GAP     = 8,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_sel,
  input  logic             req_dir,
  input  logic [CNT_W-1:0] req_steps,
  input  logic             pll_lock,
  output logic [2:0]       phase_sel,
  output logic             phase_dir,
  output logic             phase_step_n,
  output logic             load_phase,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int TO_W = (LOCK_TIMEOUT > 2) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [7:0]      GAP_LAST = 8'(STEP_GAP - 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, STEP, GAP, LOAD, WAIT_LOCK, DONE, ERR
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [7:0]       gap_q, gap_d;
  logic [TO_W-1:0]  to_q, to_d;

  logic [2:0] phase_sel_q, phase_sel_d;
  logic       phase_dir_q, phase_dir_d;
  logic       phase_step_n_q, phase_step_n_d;
  logic       load_phase_q, load_phase_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       req_ready_q, req_ready_d;

  // State, request latches, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      sel_q          <= '0;
      dir_q          <= 1'b0;
      rem_q          <= '0;
      gap_q          <= '0;
      to_q           <= '0;
      phase_sel_q    <= '0;
      phase_dir_q    <= 1'b0;
      phase_step_n_q <= 1'b1;
      load_phase_q   <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      req_ready_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      sel_q          <= sel_d;
      dir_q          <= dir_d;
      rem_q          <= rem_d;
      gap_q          <= gap_d;
      to_q           <= to_d;
      phase_sel_q    <= phase_sel_d;
      phase_dir_q    <= phase_dir_d;
      phase_step_n_q <= phase_step_n_d;
      load_phase_q   <= load_phase_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      err_q          <= err_d;
      req_ready_q    <= req_ready_d;
    end
  end

  // Next-state, request latching and counter updates.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    dir_d   = dir_q;
    rem_d   = rem_q;
    gap_d   = gap_q;
    to_d    = to_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          sel_d = req_sel;
          dir_d = req_dir;
          rem_d = req_steps;
          if (req_sel > 3'd5)          state_d = ERR;
          else if (req_steps == '0)    state_d = DONE;
          else                         state_d = SETUP;
        end
      end
      SETUP: state_d = pll_lock ? STEP : ERR;
      STEP: begin
        rem_d   = rem_q - CNT_W'(1);
        gap_d   = '0;
        state_d = pll_lock ? GAP : ERR;
      end
      GAP: begin
        if (!pll_lock)             state_d = ERR;
        else if (gap_q == GAP_LAST) state_d = (rem_q != '0) ? STEP : LOAD;
        else                       gap_d = gap_q + 8'd1;
      end
      LOAD: begin
        to_d    = '0;
        state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (pll_lock)              state_d = DONE;
        else if (to_q == TO_LAST)  state_d = ERR;
        else                       to_d = to_q + TO_W'(1);
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    phase_sel_d    = phase_sel_q;
    phase_dir_d    = phase_dir_q;
    if (state_d == SETUP) begin
      phase_sel_d = sel_d;
      phase_dir_d = dir_d;
    end
    phase_step_n_d = (state_d != STEP);
    load_phase_d   = (state_d == LOAD);
    busy_d         = (state_d != IDLE);
    done_d         = (state_d == DONE);
    err_d          = (state_d == ERR);
    req_ready_d    = (state_d == IDLE) && pll_lock;
  end

  assign phase_sel    = phase_sel_q;
  assign phase_dir    = phase_dir_q;
  assign phase_step_n = phase_step_n_q;
  assign load_phase   = load_phase_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign req_ready    = req_ready_q;

endmodule

// File: tb/tb_pll_phase_step_ctrl.sv
// Directed testbench for pll_phase_step_ctrl (STEP_GAP=8, LOCK_TIMEOUT=16).
// Cycle 0 is the cycle whose closing edge accepts a request.
module tb_pll_phase_step_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] req_sel = '0;
  logic       req_dir = 1'b0;
  logic [7:0] req_steps = '0;
  logic       pll_lock = 1'b1;
  logic [2:0] phase_sel;
  logic       phase_dir, phase_step_n, load_phase, busy, done, err;

  int checks = 0;
  int errors = 0;

  pll_phase_step_ctrl #(.STEP_GAP(8), .LOCK_TIMEOUT(16), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_sel(req_sel), .req_dir(req_dir), .req_steps(req_steps),
    .pll_lock(pll_lock), .phase_sel(phase_sel), .phase_dir(phase_dir),
    .phase_step_n(phase_step_n), .load_phase(load_phase), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] sel;
    logic       dir;
    logic [7:0] steps;
    int         drop;
    int         exp_nstep;
    int         exp_first;
    int         exp_last;
    int         exp_load;
    int         exp_done;
    int         exp_err;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    pll_lock = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("req_ready_wait", int'(req_ready), 1);
  endtask

  // Issues one request and records event cycles until one cycle past done/err.
  task automatic run_req(input logic [2:0] s, input logic d, input logic [7:0] n,
                         input int drop, output int nstep, output int first,
                         output int last, output int ld, output int dn,
                         output int er, output int bsy_after, output int psel,
                         output int pdir, output int stray);
    int evt;
    nstep = 0; first = -1; last = -1; ld = -1; dn = -1; er = -1;
    bsy_after = -1; psel = -1; pdir = -1; stray = 0; evt = -1;
    wait_ready();
    req_sel = s; req_dir = d; req_steps = n; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int c = 1; c < 5000; c++) begin
      if (c > 1) tick();
      if (evt >= 0) begin
        bsy_after = int'(busy);
        break;
      end
      if (phase_step_n === 1'b0) begin
        nstep++;
        if (first < 0) first = c;
        last = c;
      end
      if (load_phase === 1'b1 && ld < 0) ld = c;
      if (done === 1'b1 && err === 1'b1) stray++;
      if (busy === 1'b1 && req_ready === 1'b1) stray++;
      if (done === 1'b1 || err === 1'b1) begin
        if (done === 1'b1) dn = c;
        if (err === 1'b1) er = c;
        psel = int'(phase_sel);
        pdir = int'(phase_dir);
        evt = c;
      end
      if (c == drop) pll_lock = 1'b0;
    end
    if (evt < 0) chk("run_timeout", 0, 1);
    pll_lock = 1'b1;
  endtask

  initial begin
    int nstep, first, last, ld, dn, er, ba, ps, pd, stray;
    int dn1, seen_rdy, b14, b15, s16;

    //        sel   dir   n     drop nst first last load done err
    vecs[0]  = '{3'd2, 1'b1, 8'd3,   -1, 3,   2,  20,  29,  31,  -1};
    vecs[1]  = '{3'd0, 1'b0, 8'd1,   -1, 1,   2,   2,  11,  13,  -1};
    vecs[2]  = '{3'd5, 1'b1, 8'd2,   -1, 2,   2,  11,  20,  22,  -1};
    vecs[3]  = '{3'd4, 1'b0, 8'd0,   -1, 0,  -1,  -1,  -1,   1,  -1};
    vecs[4]  = '{3'd6, 1'b1, 8'd3,   -1, 0,  -1,  -1,  -1,  -1,   1};
    vecs[5]  = '{3'd7, 1'b0, 8'd0,   -1, 0,  -1,  -1,  -1,  -1,   1};
    vecs[6]  = '{3'd2, 1'b1, 8'd3,   12, 2,   2,  11,  -1,  -1,  13};
    vecs[7]  = '{3'd1, 1'b0, 8'd3,   11, 2,   2,  11,  -1,  -1,  12};
    vecs[8]  = '{3'd3, 1'b1, 8'd2,    1, 0,  -1,  -1,  -1,  -1,   2};
    vecs[9]  = '{3'd0, 1'b1, 8'd1,   11, 1,   2,   2,  11,  -1,  28};
    vecs[10] = '{3'd1, 1'b1, 8'd255, -1, 255, 2, 2288, 2297, 2299, -1};

    // Reset state
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_phase_sel", int'(phase_sel), 0);
    chk("rst_phase_dir", int'(phase_dir), 0);
    chk("rst_step_n", int'(phase_step_n), 1);
    chk("rst_load", int'(load_phase), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done_err", int'({done, err}), 0);
    chk("rst_req_ready", int'(req_ready), 0);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      run_req(vecs[i].sel, vecs[i].dir, vecs[i].steps, vecs[i].drop,
              nstep, first, last, ld, dn, er, ba, ps, pd, stray);
      chk($sformatf("v%0d_nstep", i), nstep, vecs[i].exp_nstep);
      chk($sformatf("v%0d_first", i), first, vecs[i].exp_first);
      chk($sformatf("v%0d_last", i), last, vecs[i].exp_last);
      chk($sformatf("v%0d_load", i), ld, vecs[i].exp_load);
      chk($sformatf("v%0d_done", i), dn, vecs[i].exp_done);
      chk($sformatf("v%0d_err", i), er, vecs[i].exp_err);
      chk($sformatf("v%0d_busy_after", i), ba, 0);
      chk($sformatf("v%0d_stray", i), stray, 0);
      if (vecs[i].exp_done > 1) begin
        chk($sformatf("v%0d_phase_sel", i), ps, int'(vecs[i].sel));
        chk($sformatf("v%0d_phase_dir", i), pd, int'(vecs[i].dir));
      end
    end

    // Reset for one cycle during GAP of a 5-step request
    wait_ready();
    req_sel = 3'd3; req_dir = 1'b1; req_steps = 8'd5; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick(); tick(); tick(); tick();
    chk("mid_in_gap_busy", int'(busy), 1);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_step_n", int'(phase_step_n), 1);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_load", int'(load_phase), 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_req_ready", int'(req_ready), int'(pll_lock));
    chk("post_rst_busy", int'(busy), 0);
    run_req(3'd3, 1'b1, 8'd5, -1, nstep, first, last, ld, dn, er, ba, ps, pd, stray);
    chk("rerun_nstep", nstep, 5);
    chk("rerun_last", last, 38);
    chk("rerun_load", ld, 47);
    chk("rerun_done", dn, 49);

    // Back-to-back with req_valid held high
    wait_ready();
    req_sel = 3'd0; req_dir = 1'b1; req_steps = 8'd1; req_valid = 1'b1;
    tick();
    dn1 = -1; seen_rdy = 0; b14 = -1; b15 = -1; s16 = -1;
    for (int c = 1; c <= 16; c++) begin
      if (c > 1) tick();
      if (done === 1'b1 && dn1 < 0) dn1 = c;
      if (c <= 13 && req_ready === 1'b1) seen_rdy++;
      if (c == 14) b14 = int'(busy);
      if (c == 15) begin
        b15 = int'(busy);
        req_valid = 1'b0;
      end
      if (c == 16) s16 = int'(phase_step_n);
    end
    chk("b2b_first_done", dn1, 13);
    chk("b2b_ready_while_busy", seen_rdy, 0);
    chk("b2b_idle_gap_busy", b14, 0);
    chk("b2b_second_busy", b15, 1);
    chk("b2b_second_step_n", s16, 0);
    dn1 = -1;
    for (int c = 17; c < 60; c++) begin
      tick();
      if (done === 1'b1) begin
        dn1 = c;
        break;
      end
    end
    chk("b2b_second_done", dn1, 27);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
